// File: rtl/counter.sv
// Up-counter from 0 to MAX_COUNTER_VALUE with enable. finished_o is high while the count sits at the maximum.
// Optional COUNTER_AUTO_RELOAD_EN: an enabled edge at the maximum wraps the count to 0 instead of saturating.
`timescale 1ns/1ps

module counter #(
    parameter int MAX_COUNTER_VALUE = 10
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   enable_i,
    output logic                                   finished_o,
    output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0] counter_val_o
);

    localparam int W = $clog2(MAX_COUNTER_VALUE + 1);
    localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNTER_VALUE);

    logic [W-1:0] count;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (enable_i) begin
            if (count != MAX_VAL) begin
                count <= count + 1'b1;
            end
`ifdef COUNTER_AUTO_RELOAD_EN
            else begin
                count <= '0;
            end
`endif
        end
    end

    // Decoded from the register only, so it rises together with the terminal count.
    assign finished_o    = (count == MAX_VAL);
    assign counter_val_o = count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: the stimulus pushes an expected value per cycle, and a monitor pops and compares it on the falling edge.
// Two instances are covered: MAX_COUNTER_VALUE = 10 and MAX_COUNTER_VALUE = 1.
`timescale 1ns/1ps

module tb_counter;

    typedef struct packed {
        logic       sel;
        logic [7:0] val;
        logic       fin;
    } exp_t;

    logic       clock_i;
    logic       reset_i, enable_i;
    logic       reset1, enable1;
    logic       finished_o, finished1;
    logic [3:0] counter_val_o;
    logic [0:0] counter_val1;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    counter #(.MAX_COUNTER_VALUE(10)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .finished_o   (finished_o),
        .counter_val_o(counter_val_o)
    );

    counter #(.MAX_COUNTER_VALUE(1)) dut1 (
        .clock_i      (clock_i),
        .reset_i      (reset1),
        .enable_i     (enable1),
        .finished_o   (finished1),
        .counter_val_o(counter_val1)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Monitor: outputs only move on rising edges or reset, so the falling edge is a stable sampling point.
    initial begin
        exp_t  e;
        string n;
        int    act_val;
        logic  act_fin;
        forever begin
            @(negedge clock_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act_val = e.sel ? int'(counter_val1) : int'(counter_val_o);
                act_fin = e.sel ? finished1 : finished_o;
                total++;
                if (act_val != int'(e.val) || act_fin !== e.fin) begin
                    bad++;
                    $display("FAIL %s at %0t: got val=%0d fin=%b, want val=%0d fin=%b",
                             n, $time, act_val, act_fin, e.val, e.fin);
                end
            end
        end
    end

    // Applies enable for the next rising edge and queues the state expected after that edge.
    task automatic cyc(input logic sel, input logic en, input int val, input logic fin, input string nm);
        exp_t e;
        if (sel) enable1 = en;
        else     enable_i = en;
        e.sel = sel;
        e.val = 8'(val);
        e.fin = fin;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clock_i);
        #1;
    endtask

    initial begin
        int ev;
        reset_i  = 1'b1;
        enable_i = 1'b0;
        reset1   = 1'b1;
        enable1  = 1'b0;
        @(negedge clock_i);
        #1;

        // Enable during reset has no effect.
        cyc(1'b0, 1'b1, 0, 1'b0, "reset_enable_ignored");
        reset_i = 1'b0;
        cyc(1'b0, 1'b0, 0, 1'b0, "idle_after_reset");
        cyc(1'b0, 1'b0, 0, 1'b0, "idle_after_reset");

        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, i, 1'b0, "count_up_first");
        cyc(1'b0, 1'b0, 5, 1'b0, "hold");
        cyc(1'b0, 1'b0, 5, 1'b0, "hold");
        for (int i = 6; i <= 10; i++) cyc(1'b0, 1'b1, i, (i == 10), "count_up_resume");

        for (int k = 1; k <= 13; k++) begin
`ifdef COUNTER_AUTO_RELOAD_EN
            ev = (k - 1) % 11;
`else
            ev = 10;
`endif
            cyc(1'b0, 1'b1, ev, (ev == 10), "terminal");
        end

        // Reset to a known state, count to 7, then hit it with a reset between clock edges.
        reset_i = 1'b1;
        cyc(1'b0, 1'b0, 0, 1'b0, "reset_clear");
        reset_i = 1'b0;
        for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, i, 1'b0, "count_to_7");
        cyc(1'b0, 1'b0, 7, 1'b0, "hold_7");
        @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        exp_q.push_back('{sel: 1'b0, val: 8'd0, fin: 1'b0});
        name_q.push_back("async_reset_midcycle");
        @(negedge clock_i);
        #1;
        cyc(1'b0, 1'b1, 0, 1'b0, "reset_priority");
        #2;
        reset_i = 1'b0;
        cyc(1'b0, 1'b1, 1, 1'b0, "restart_after_reset");
        cyc(1'b0, 1'b1, 2, 1'b0, "restart_after_reset");
        enable_i = 1'b0;

        // MAX_COUNTER_VALUE = 1 instance
        cyc(1'b1, 1'b0, 0, 1'b0, "max1_reset");
        reset1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
`ifdef COUNTER_AUTO_RELOAD_EN
            ev = k % 2;
`else
            ev = 1;
`endif
            cyc(1'b1, 1'b1, ev, (ev == 1), "max1_run");
        end
        enable1 = 1'b0;

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
